seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_if.sv | 27 ++
 rtl/seq_alu.sv | 165 ++++++++++++++++
 tb/tb_seq_alu.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// Request/response bus of the sequential ALU: valid/ready on both sides plus result flags.
interface seq_alu_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned OPW   = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, out, flag_z, flag_c, flag_v
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, out, flag_z, flag_c, flag_v
  );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/add/shift ops, WIDTH-iteration shift-add multiply
// and restoring divide, with a registered result held until the consumer takes it.
module seq_alu #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned OPW   = 6
) (
  input logic      clk,
  input logic      rst_n,
  seq_alu_if.slave bus
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
  localparam logic [OPW-1:0] OP_AND  = OPW'(2);
  localparam logic [OPW-1:0] OP_OR   = OPW'(3);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(4);
  localparam logic [OPW-1:0] OP_SHL  = OPW'(5);
  localparam logic [OPW-1:0] OP_SHR  = OPW'(6);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(7);
  localparam logic [OPW-1:0] OP_DIVU = OPW'(8);
  localparam logic [OPW-1:0] OP_REMU = OPW'(9);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] out_q;
  logic             out_valid_q;
  logic             z_q, c_q, v_q;

  logic             accept_c;
  logic             multi_c;
  logic [WIDTH:0]   add_s, sub_s;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic [WIDTH:0]   mul_sum, div_r, div_t;
  logic [WIDTH-1:0] hi_d, lo_d, m_res;
  logic             m_c, m_v;

  assign accept_c = bus.in_valid && (state_q == IDLE);
  assign multi_c  = (bus.op == OP_MUL) || (bus.op == OP_DIVU) || (bus.op == OP_REMU);

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.flag_z    = z_q;
  assign bus.flag_c    = c_q;
  assign bus.flag_v    = v_q;

  // Single-cycle result, computed straight from the request being accepted.
  always_comb begin
    add_s   = {1'b0, bus.a} + {1'b0, bus.b};
    sub_s   = {1'b0, bus.a} - {1'b0, bus.b};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_res = add_s[WIDTH-1:0];
        alu_c   = add_s[WIDTH];
        alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_s[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_s[WIDTH-1:0];
        alu_c   = sub_s[WIDTH];
        alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_s[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_SHL:  alu_res = bus.a << bus.b[SW-1:0];
      OP_SHR:  alu_res = bus.a >> bus.b[SW-1:0];
      default: alu_res = '0;
    endcase
  end

  // One iteration: MUL keeps {hi,lo} as the product shifting right; divide keeps
  // hi as partial remainder and lo as dividend shifting left into the quotient.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_r   = {hi_q, lo_q[WIDTH-1]};
    div_t   = div_r - {1'b0, opnd_q};
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (op_q == OP_MUL) begin
      hi_d = mul_sum[WIDTH:1];
      lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else if (!div_t[WIDTH]) begin
      hi_d = div_t[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      hi_d = div_r[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], 1'b0};
    end
    m_res = (op_q == OP_REMU) ? hi_d : lo_d;
    m_c   = (op_q == OP_MUL) && (hi_d != '0);
    m_v   = (op_q != OP_MUL) && (opnd_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      opnd_q      <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            op_q  <= bus.op;
            cnt_q <= '0;
            if (multi_c) begin
              state_q <= BUSY;
              hi_q    <= '0;
              opnd_q  <= (bus.op == OP_MUL) ? bus.a : bus.b;
              lo_q    <= (bus.op == OP_MUL) ? bus.b : bus.a;
            end else begin
              state_q     <= DONE;
              out_q       <= alu_res;
              z_q         <= (alu_res == '0);
              c_q         <= alu_c;
              v_q         <= alu_v;
              out_valid_q <= 1'b1;
            end
          end
        end
        BUSY: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q     <= DONE;
            out_q       <= m_res;
            z_q         <= (m_res == '0);
            c_q         <= m_c;
            v_q         <= m_v;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Randomised self-checking bench for seq_alu against an arithmetic reference model.
module tb_seq_alu;

  localparam int unsigned W   = 16;
  localparam int unsigned OPW = 6;
  localparam longint SMAX = (longint'(1) << (W - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (W - 1));

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  seq_alu_if #(.WIDTH(W), .OPW(OPW)) ifc ();

  seq_alu #(.WIDTH(W), .OPW(OPW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: result and flags from the opcode definitions using 64-bit arithmetic.
  task automatic model(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic c, output logic v);
    longint ua, ub, sa, sb, s;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      0: begin
        s = ua + ub;
        r = W'(s);
        c = (s >= (longint'(1) << W));
        v = ((sa + sb) > SMAX) || ((sa + sb) < SMIN);
      end
      1: begin
        r = W'(ua - ub);
        c = (ua < ub);
        v = ((sa - sb) > SMAX) || ((sa - sb) < SMIN);
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = W'(ua << (ub % W));
      6: r = W'(ua >> (ub % W));
      7: begin
        s = ua * ub;
        r = W'(s);
        c = ((s >> W) != 0);
      end
      8: begin
        v = (ub == 0);
        r = (ub == 0) ? '1 : W'(ua / ub);
      end
      9: begin
        v = (ub == 0);
        r = (ub == 0) ? a : W'(ua % ub);
      end
      default: r = '0;
    endcase
  endtask

  task automatic run_op(input logic [OPW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input string tag);
    logic [W-1:0] er, held;
    logic ec, ev;
    int lat, exp_lat, wait_n;
    bit rdy_low_ok, stable_ok;
    model(int'(op), a, b, er, ec, ev);
    exp_lat = (op == OPW'(7) || op == OPW'(8) || op == OPW'(9)) ? W + 1 : 1;
    ifc.in_valid = 1'b1;
    ifc.op = op;
    ifc.a  = a;
    ifc.b  = b;
    wait_n = 0;
    while (!ifc.in_ready && wait_n < 50) begin
      @(posedge clk); #1;
      wait_n++;
    end
    check_eq({tag, " in_ready_before_accept"}, 64'(ifc.in_ready), 64'd1);
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    ifc.op = OPW'($urandom);
    ifc.a  = W'($urandom);
    ifc.b  = W'($urandom);
    lat = 1;
    rdy_low_ok = 1'b1;
    while (!ifc.out_valid && lat < 200) begin
      if (ifc.in_ready) rdy_low_ok = 1'b0;
      ifc.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    if (ifc.in_ready) rdy_low_ok = 1'b0;
    ifc.out_ready = 1'b0;
    check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, " in_ready_low_while_busy"}, 64'(rdy_low_ok), 64'd1);
    check_eq({tag, " out"}, 64'(ifc.out), 64'(er));
    check_eq({tag, " flag_z"}, 64'(ifc.flag_z), 64'(er == '0));
    check_eq({tag, " flag_c"}, 64'(ifc.flag_c), 64'(ec));
    check_eq({tag, " flag_v"}, 64'(ifc.flag_v), 64'(ev));
    held = ifc.out;
    stable_ok = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
      if (ifc.out !== held || !ifc.out_valid || ifc.in_ready) stable_ok = 1'b0;
    end
    if (hold > 0) check_eq({tag, " held_under_backpressure"}, 64'(stable_ok), 64'd1);
    ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    ifc.out_ready = 1'b0;
    check_eq({tag, " out_valid_after_take"}, 64'(ifc.out_valid), 64'd0);
    check_eq({tag, " in_ready_after_take"}, 64'(ifc.in_ready), 64'd1);
    check_eq({tag, " out_retained"}, 64'(ifc.out), 64'(er));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OPW-1:0] rop;
    logic [W-1:0]   ra, rb;
    bit             stale;
    int             sel;
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b0;
    ifc.op = '0;
    ifc.a  = '0;
    ifc.b  = '0;
    #12;
    check_eq("reset in_ready", 64'(ifc.in_ready), 64'd1);
    check_eq("reset out_valid", 64'(ifc.out_valid), 64'd0);
    check_eq("reset out", 64'(ifc.out), 64'd0);
    check_eq("reset flags", 64'({ifc.flag_z, ifc.flag_c, ifc.flag_v}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(OPW'(0), 16'hFFFF, 16'h0001, 0, "add_wrap");
    run_op(OPW'(1), 16'h8000, 16'h0001, 0, "sub_ovf");
    run_op(OPW'(1), 16'h0001, 16'h0002, 1, "sub_borrow");
    run_op(OPW'(7), 16'h0123, 16'h0010, 0, "mul");
    run_op(OPW'(7), 16'h8000, 16'h0002, 0, "mul_hi");
    run_op(OPW'(8), 16'd100, 16'd7, 0, "divu");
    run_op(OPW'(9), 16'd100, 16'd7, 0, "remu");
    run_op(OPW'(8), 16'h1234, 16'h0000, 0, "divu_by0");
    run_op(OPW'(9), 16'h1234, 16'h0000, 0, "remu_by0");
    run_op(OPW'(4), 16'h00FF, 16'h0F0F, 5, "xor_backpressure");
    run_op(OPW'(5), 16'h0001, 16'hFFF3, 0, "shl_amount_masked");
    run_op(OPW'(6), 16'h8000, 16'h0010, 0, "shr_amount_zero");
    run_op(OPW'(63), 16'h1234, 16'h5678, 0, "unknown_op");

    // Reset in the middle of a multiply must drop it without a late result.
    ifc.in_valid = 1'b1;
    ifc.op = OPW'(7);
    ifc.a  = 16'h0123;
    ifc.b  = 16'h0010;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midreset out_valid", 64'(ifc.out_valid), 64'd0);
    check_eq("midreset in_ready", 64'(ifc.in_ready), 64'd1);
    check_eq("midreset out", 64'(ifc.out), 64'd0);
    check_eq("midreset flags", 64'({ifc.flag_z, ifc.flag_c, ifc.flag_v}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (ifc.out_valid || !ifc.in_ready) stale = 1'b1;
    end
    check_eq("midreset no_stale_result", 64'(stale), 64'd0);

    for (int i = 0; i < 150; i++) begin
      sel = int'($urandom_range(0, 11));
      if (sel <= 9) rop = OPW'(sel);
      else if (sel == 10) rop = OPW'(63);
      else rop = OPW'(10 + $urandom_range(0, 20));
      ra = W'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 15));
        default: rb = W'($urandom);
      endcase
      run_op(rop, ra, rb, int'($urandom_range(0, 3)), $sformatf("rand%0d_op%0d", i, rop));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
